// File: rtl/rf_arb_pkg.sv
// Shared types for the register-file write-port arbiter: entry layout,
// starvation FSM states and architectural widths.
package rf_arb_pkg;

    localparam int REG_AW = 5;
    localparam int XLEN   = 32;
    localparam int NREGS  = 1 << REG_AW;

    typedef struct packed {
        logic              live;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   wd;
    } arb_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        STARVED
    } arb_state_t;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Bus bundle between the pipeline/MDU side and the write-port arbiter.
// The arbiter uses the slave modport; whoever drives WB and MDU uses master.
interface rf_wb_arbiter_if;
    import rf_arb_pkg::*;

    logic              wb_we;
    logic [REG_AW-1:0] wb_rd;
    logic [XLEN-1:0]   wb_wd;
    logic              mdu_valid;
    logic [REG_AW-1:0] mdu_rd;
    logic [XLEN-1:0]   mdu_wd;
    logic              mdu_ready;
    logic              rf_we;
    logic [REG_AW-1:0] rf_a3;
    logic [XLEN-1:0]   rf_wd;
    logic [NREGS-1:0]  pend_mask;
    logic              stall_req;

    modport master (
        output wb_we, wb_rd, wb_wd, mdu_valid, mdu_rd, mdu_wd,
        input  mdu_ready, rf_we, rf_a3, rf_wd, pend_mask, stall_req
    );

    modport slave (
        input  wb_we, wb_rd, wb_wd, mdu_valid, mdu_rd, mdu_wd,
        output mdu_ready, rf_we, rf_a3, rf_wd, pend_mask, stall_req
    );

endinterface

// File: rtl/rf_arb_fifo.sv
// MDU result FIFO: per-entry live flag that a matching WB write can kill,
// plus the pending-destination mask derived from the live entries.
module rf_arb_fifo
    import rf_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  arb_entry_t        push_entry,
    input  logic              pop,
    input  logic              kill_en,
    input  logic [REG_AW-1:0] kill_rd,
    output arb_entry_t        head,
    output logic              empty,
    output logic              empty_nxt,
    output logic              full_nxt,
    output logic [NREGS-1:0]  pend_mask
`ifdef RF_WB_ARBITER_STATS_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] kill_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0]  live_q, live_d;
    logic [REG_AW-1:0] rd_q [DEPTH];
    logic [REG_AW-1:0] rd_d [DEPTH];
    logic [XLEN-1:0]   wd_q [DEPTH];
    logic [XLEN-1:0]   wd_d [DEPTH];
    logic [AW-1:0]     wr_idx, rd_idx;

    assign wr_idx = wr_ptr_q[AW-1:0];
    assign rd_idx = rd_ptr_q[AW-1:0];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        live_d = live_q;
        rd_d   = rd_q;
        wd_d   = wd_q;
`ifdef RF_WB_ARBITER_STATS_EN
        kill_cnt = '0;
`endif
        // Younger WB write to the same register supersedes queued results.
        for (int i = 0; i < DEPTH; i++) begin
            if (kill_en && live_q[i] && rd_q[i] == kill_rd) begin
                live_d[i] = 1'b0;
`ifdef RF_WB_ARBITER_STATS_EN
                kill_cnt = kill_cnt + ($clog2(DEPTH+1))'(1);
`endif
            end
        end
        if (pop) live_d[rd_idx] = 1'b0;
        if (push) begin
            live_d[wr_idx] = push_entry.live;
            rd_d[wr_idx]   = push_entry.rd;
            wd_d[wr_idx]   = push_entry.wd;
        end
        wr_ptr_d = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
    end

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign empty_nxt = (wr_ptr_d == rd_ptr_d);
    assign full_nxt  = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                       (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);

    always_comb begin
        head.live = live_q[rd_idx];
        head.rd   = rd_q[rd_idx];
        head.wd   = wd_q[rd_idx];
    end

    // Popped slots drop their live flag, so all live flags lie inside the occupied range.
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i]) pend_mask[rd_q[i]] = 1'b1;
        end
        pend_mask[0] = 1'b0;
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            live_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            live_q   <= live_d;
        end
    end

    // NOTE: payload storage is not reset; the live flags and pointers alone define validity.
    always_ff @(posedge clk) begin
        rd_q <= rd_d;
        wd_q <= wd_d;
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: WB priority mux, MDU drain, starvation FSM.
// Define RF_WB_ARBITER_STATS_EN to add saturating write/kill/starve counters.
module rf_wb_arbiter
    import rf_arb_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    rf_wb_arbiter_if.slave    bus
`ifdef RF_WB_ARBITER_STATS_EN
    ,
    output logic [XLEN-1:0]   stat_mdu_writes,
    output logic [XLEN-1:0]   stat_kills,
    output logic [XLEN-1:0]   stat_starves
`endif
);

    localparam int CW = $clog2(STARVE_MAX) + 1;

    logic       wb_active, push, pop, mdu_ready;
    logic       fifo_empty, fifo_empty_nxt, fifo_full_nxt;
    logic       ready_q, ready_d, stall_q, stall_d;
    arb_entry_t push_entry, head;
    arb_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
`ifdef RF_WB_ARBITER_STATS_EN
    logic [$clog2(DEPTH+1)-1:0] kill_cnt;
`endif

    assign wb_active = bus.wb_we && (bus.wb_rd != '0);
    assign mdu_ready = ready_q && !rst;
    assign push      = bus.mdu_valid && mdu_ready;
    assign pop       = !rst && !wb_active && !fifo_empty;

    always_comb begin
        push_entry.rd   = bus.mdu_rd;
        push_entry.wd   = bus.mdu_wd;
        push_entry.live = (bus.mdu_rd != '0) && !(wb_active && bus.mdu_rd == bus.wb_rd);
    end

    rf_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .kill_en    (wb_active && !rst),
        .kill_rd    (bus.wb_rd),
        .head       (head),
        .empty      (fifo_empty),
        .empty_nxt  (fifo_empty_nxt),
        .full_nxt   (fifo_full_nxt),
        .pend_mask  (bus.pend_mask)
`ifdef RF_WB_ARBITER_STATS_EN
        ,
        .kill_cnt   (kill_cnt)
`endif
    );

    always_comb begin
        bus.rf_we = 1'b0;
        bus.rf_a3 = '0;
        bus.rf_wd = '0;
        if (!rst) begin
            if (wb_active) begin
                bus.rf_we = 1'b1;
                bus.rf_a3 = bus.wb_rd;
                bus.rf_wd = bus.wb_wd;
            end else if (!fifo_empty && head.live) begin
                bus.rf_we = 1'b1;
                bus.rf_a3 = head.rd;
                bus.rf_wd = head.wd;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = !fifo_full_nxt;
        if (fifo_empty_nxt) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
                WAIT: begin
                    // With a non-empty FIFO, "no pop" means WB held the port this cycle.
                    if (pop)                             cnt_d   = '0;
                    else if (cnt_q == CW'(STARVE_MAX-1)) state_d = STARVED;
                    else                                 cnt_d   = cnt_q + CW'(1);
                end
                STARVED: begin
                    if (pop) begin
                        state_d = WAIT;
                        cnt_d   = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        stall_d = (state_d == STARVED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            stall_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            ready_q <= ready_d;
        end
    end

    assign bus.mdu_ready = mdu_ready;
    assign bus.stall_req = stall_q;

`ifdef RF_WB_ARBITER_STATS_EN
    logic [XLEN-1:0] writes_q, writes_d, kills_q, kills_d, starves_q, starves_d;
    logic [XLEN:0]   kill_sum;

    always_comb begin
        writes_d  = writes_q;
        starves_d = starves_q;
        if (pop && head.live && writes_q != '1) writes_d = writes_q + XLEN'(1);
        if (state_q == WAIT && state_d == STARVED && starves_q != '1)
            starves_d = starves_q + XLEN'(1);
        kill_sum = {1'b0, kills_q} + (XLEN+1)'(kill_cnt);
        kills_d  = kill_sum[XLEN] ? '1 : kill_sum[XLEN-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            writes_q  <= '0;
            kills_q   <= '0;
            starves_q <= '0;
        end else begin
            writes_q  <= writes_d;
            kills_q   <= kills_d;
            starves_q <= starves_d;
        end
    end

    assign stat_mdu_writes = writes_q;
    assign stat_kills      = kills_q;
    assign stat_starves    = starves_q;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed vector table, hand sequences for
// starvation and mid-operation reset, then random traffic against a queue model.
module tb_rf_wb_arbiter;
    import rf_arb_pkg::*;

    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 8;
    localparam int N_RANDOM   = 3000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    rf_wb_arbiter_if bus();

`ifdef RF_WB_ARBITER_STATS_EN
    logic [31:0] stat_mdu_writes, stat_kills, stat_starves;
    rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .stat_mdu_writes(stat_mdu_writes), .stat_kills(stat_kills), .stat_starves(stat_starves)
    );
`else
    rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_wd;
        logic        mdu_valid;
        logic [4:0]  mdu_rd;
        logic [31:0] mdu_wd;
        logic        e_we;
        logic [4:0]  e_a3;
        logic [31:0] e_wd;
        logic        e_ready;
        logic [31:0] e_pend;
        logic        e_stall;
    } vec_t;

    typedef struct {
        bit        live;
        bit [4:0]  rd;
        bit [31:0] wd;
    } m_ent_t;

    vec_t   tbl[$];
    m_ent_t mq[$];
    int     run;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic we, input logic [4:0] wrd, input logic [31:0] wwd,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] mwd);
        rst           = r;
        bus.wb_we     = we;
        bus.wb_rd     = wrd;
        bus.wb_wd     = wwd;
        bus.mdu_valid = mv;
        bus.mdu_rd    = mrd;
        bus.mdu_wd    = mwd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic r, input logic we, input logic [4:0] wrd, input logic [31:0] wwd,
                                input logic mv, input logic [4:0] mrd, input logic [31:0] mwd,
                                input logic ewe, input logic [4:0] ea3, input logic [31:0] ewd,
                                input logic erdy, input logic [31:0] epend, input logic estall);
        vec_t v;
        v.rst = r; v.wb_we = we; v.wb_rd = wrd; v.wb_wd = wwd;
        v.mdu_valid = mv; v.mdu_rd = mrd; v.mdu_wd = mwd;
        v.e_we = ewe; v.e_a3 = ea3; v.e_wd = ewd;
        v.e_ready = erdy; v.e_pend = epend; v.e_stall = estall;
        return v;
    endfunction

    initial begin
        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        repeat (3) next_cycle();

        // rst, wb_we, wb_rd, wb_wd, mdu_valid, mdu_rd, mdu_wd | rf_we, a3, wd, ready, pend, stall
        tbl.push_back(mk(1, 0, 0, 32'h0,    0, 0,  32'h0,    0, 0,  32'h0,    0, 32'h0,    0));
        tbl.push_back(mk(0, 0, 0, 32'h0,    0, 0,  32'h0,    0, 0,  32'h0,    1, 32'h0,    0));
        tbl.push_back(mk(0, 0, 0, 32'h0,    1, 5,  32'h1234, 0, 0,  32'h0,    1, 32'h0,    0));
        tbl.push_back(mk(0, 0, 0, 32'h0,    0, 0,  32'h0,    1, 5,  32'h1234, 1, 32'h20,   0));
        tbl.push_back(mk(0, 0, 0, 32'h0,    0, 0,  32'h0,    0, 0,  32'h0,    1, 32'h0,    0));
        tbl.push_back(mk(0, 0, 0, 32'h0,    1, 9,  32'h99,   0, 0,  32'h0,    1, 32'h0,    0));
        tbl.push_back(mk(0, 1, 3, 32'hAA,   0, 0,  32'h0,    1, 3,  32'hAA,   1, 32'h200,  0));
        tbl.push_back(mk(0, 0, 0, 32'h0,    0, 0,  32'h0,    1, 9,  32'h99,   1, 32'h200,  0));
        tbl.push_back(mk(0, 0, 0, 32'h0,    0, 0,  32'h0,    0, 0,  32'h0,    1, 32'h0,    0));
        tbl.push_back(mk(0, 0, 0, 32'h0,    1, 7,  32'h77,   0, 0,  32'h0,    1, 32'h0,    0));
        tbl.push_back(mk(0, 1, 7, 32'h55,   0, 0,  32'h0,    1, 7,  32'h55,   1, 32'h80,   0));
        tbl.push_back(mk(0, 0, 0, 32'h0,    0, 0,  32'h0,    0, 0,  32'h0,    1, 32'h0,    0));
        tbl.push_back(mk(0, 0, 0, 32'h0,    0, 0,  32'h0,    0, 0,  32'h0,    1, 32'h0,    0));
        tbl.push_back(mk(0, 1, 4, 32'h44,   1, 4,  32'h1,    1, 4,  32'h44,   1, 32'h0,    0));
        tbl.push_back(mk(0, 0, 0, 32'h0,    0, 0,  32'h0,    0, 0,  32'h0,    1, 32'h0,    0));
        tbl.push_back(mk(0, 1, 1, 32'h11,   1, 10, 32'hA0,   1, 1,  32'h11,   1, 32'h0,    0));
        tbl.push_back(mk(0, 1, 2, 32'h22,   1, 11, 32'hB0,   1, 2,  32'h22,   1, 32'h400,  0));
        tbl.push_back(mk(0, 1, 1, 32'h12,   1, 12, 32'hC0,   1, 1,  32'h12,   0, 32'hC00,  0));
        tbl.push_back(mk(0, 0, 0, 32'h0,    1, 12, 32'hC0,   1, 10, 32'hA0,   0, 32'hC00,  0));
        tbl.push_back(mk(0, 0, 0, 32'h0,    0, 0,  32'h0,    1, 11, 32'hB0,   1, 32'h800,  0));
        tbl.push_back(mk(0, 1, 0, 32'hDEAD, 0, 0,  32'h0,    0, 0,  32'h0,    1, 32'h0,    0));
        tbl.push_back(mk(0, 0, 0, 32'h0,    1, 0,  32'h5,    0, 0,  32'h0,    1, 32'h0,    0));
        tbl.push_back(mk(0, 0, 0, 32'h0,    0, 0,  32'h0,    0, 0,  32'h0,    1, 32'h0,    0));
        tbl.push_back(mk(0, 0, 0, 32'h0,    0, 0,  32'h0,    0, 0,  32'h0,    1, 32'h0,    0));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].wb_we, tbl[i].wb_rd, tbl[i].wb_wd,
                  tbl[i].mdu_valid, tbl[i].mdu_rd, tbl[i].mdu_wd);
            @(negedge clk);
            check($sformatf("vec%0d_rf_we", i), 32'(bus.rf_we), 32'(tbl[i].e_we));
            check($sformatf("vec%0d_rf_a3", i), 32'(bus.rf_a3), 32'(tbl[i].e_a3));
            check($sformatf("vec%0d_rf_wd", i), bus.rf_wd, tbl[i].e_wd);
            check($sformatf("vec%0d_ready", i), 32'(bus.mdu_ready), 32'(tbl[i].e_ready));
            check($sformatf("vec%0d_pend", i), bus.pend_mask, tbl[i].e_pend);
            check($sformatf("vec%0d_stall", i), 32'(bus.stall_req), 32'(tbl[i].e_stall));
            next_cycle();
        end

        // Starvation: one queued result, WB holds the port for 10 cycles.
        drive(0, 0, 0, 32'h0, 1, 6, 32'h66);
        @(negedge clk);
        check("starve_push_stall", 32'(bus.stall_req), 32'h0);
        next_cycle();
        for (int c = 1; c <= 10; c++) begin
            drive(0, 1, 1, 32'h100 + 32'(c), 0, 0, 32'h0);
            @(negedge clk);
            check($sformatf("starve_c%0d_stall", c), 32'(bus.stall_req), (c >= 9) ? 32'h1 : 32'h0);
            check($sformatf("starve_c%0d_a3", c), 32'(bus.rf_a3), 32'h1);
            check($sformatf("starve_c%0d_pend", c), bus.pend_mask, 32'h40);
            next_cycle();
        end
        drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
        @(negedge clk);
        check("starve_pop_we", 32'(bus.rf_we), 32'h1);
        check("starve_pop_a3", 32'(bus.rf_a3), 32'h6);
        check("starve_pop_wd", bus.rf_wd, 32'h66);
        check("starve_pop_stall", 32'(bus.stall_req), 32'h1);
        next_cycle();
        @(negedge clk);
        check("starve_after_stall", 32'(bus.stall_req), 32'h0);
        check("starve_after_we", 32'(bus.rf_we), 32'h0);
        next_cycle();

        // Reset while the FIFO is full: queued results must never reach the RF.
        drive(0, 1, 2, 32'h2, 1, 8, 32'h88);
        next_cycle();
        drive(0, 1, 2, 32'h3, 1, 9, 32'h99);
        next_cycle();
        drive(1, 0, 0, 32'h0, 0, 0, 32'h0);
        @(negedge clk);
        check("rstmid_c0_we", 32'(bus.rf_we), 32'h0);
        check("rstmid_c0_ready", 32'(bus.mdu_ready), 32'h0);
        next_cycle();
        @(negedge clk);
        check("rstmid_c1_we", 32'(bus.rf_we), 32'h0);
        check("rstmid_c1_pend", bus.pend_mask, 32'h0);
        check("rstmid_c1_stall", 32'(bus.stall_req), 32'h0);
        next_cycle();
        drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
        @(negedge clk);
        check("rstmid_rel_we", 32'(bus.rf_we), 32'h0);
        check("rstmid_rel_pend", bus.pend_mask, 32'h0);
        check("rstmid_rel_ready", 32'(bus.mdu_ready), 32'h1);
        next_cycle();
        @(negedge clk);
        check("rstmid_idle_we", 32'(bus.rf_we), 32'h0);
        next_cycle();

        // Random traffic against a queue-based model; FIFO is empty here.
        mq.delete();
        run = 0;
        for (int i = 0; i < N_RANDOM; i++) begin
            int          wb_pct, pre;
            logic        r, we, mv, wb_act, popped, e_we, e_ready;
            logic [4:0]  wrd, mrd, e_a3;
            logic [31:0] wwd, mwd, e_wd, e_pend;
            case ((i / 200) % 3)
                0:       wb_pct = 90;
                1:       wb_pct = 40;
                default: wb_pct = 10;
            endcase
            r   = ($urandom_range(0, 99) < 2);
            we  = ($urandom_range(0, 99) < wb_pct);
            wrd = 5'($urandom_range(0, 7));
            wwd = $urandom;
            mv  = ($urandom_range(0, 99) < 50);
            mrd = 5'($urandom_range(0, 7));
            mwd = $urandom;
            drive(r, we, wrd, wwd, mv, mrd, mwd);

            wb_act = we && (wrd != 0);
            e_we = 0; e_a3 = 0; e_wd = 0;
            if (!r) begin
                if (wb_act) begin
                    e_we = 1; e_a3 = wrd; e_wd = wwd;
                end else if (mq.size() > 0 && mq[0].live) begin
                    e_we = 1; e_a3 = mq[0].rd; e_wd = mq[0].wd;
                end
            end
            e_ready = !r && (mq.size() < DEPTH);
            e_pend  = 32'h0;
            foreach (mq[k]) if (mq[k].live) e_pend[mq[k].rd] = 1'b1;

            @(negedge clk);
            check("rnd_rf_we", 32'(bus.rf_we), 32'(e_we));
            check("rnd_rf_a3", 32'(bus.rf_a3), 32'(e_a3));
            check("rnd_rf_wd", bus.rf_wd, e_wd);
            check("rnd_ready", 32'(bus.mdu_ready), 32'(e_ready));
            if (!r) begin
                check("rnd_pend", bus.pend_mask, e_pend);
                check("rnd_stall", 32'(bus.stall_req), (run >= STARVE_MAX) ? 32'h1 : 32'h0);
            end

            if (r) begin
                mq.delete();
                run = 0;
            end else begin
                pre    = mq.size();
                popped = !wb_act && (pre > 0);
                if (popped) void'(mq.pop_front());
                if (wb_act) foreach (mq[k]) if (mq[k].rd == wrd) mq[k].live = 0;
                if (mv && e_ready)
                    mq.push_back('{live: (mrd != 0) && !(wb_act && mrd == wrd), rd: mrd, wd: mwd});
                if (popped || mq.size() == 0) run = 0;
                else if (pre > 0)             run++;
                else                          run = 0;
            end
            next_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
